// File: rtl/parking_gate_sequencer_pkg.sv
// Shared definitions for the parking gate sequencer and the occupancy counter.
// The state codes and the inc/dec command encodings are common to both blocks.
package parking_gate_sequencer_pkg;

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_EN1      = 4'd1;
  localparam logic [3:0] ST_EN2      = 4'd2;
  localparam logic [3:0] ST_EN3      = 4'd3;
  localparam logic [3:0] ST_EX1      = 4'd4;
  localparam logic [3:0] ST_EX2      = 4'd5;
  localparam logic [3:0] ST_EX3      = 4'd6;
  localparam logic [3:0] ST_ERR      = 4'd7;
  localparam logic [3:0] ST_WAIT_CLR = 4'd8;

  typedef enum logic [3:0] {
    IDLE     = ST_IDLE,
    EN1      = ST_EN1,
    EN2      = ST_EN2,
    EN3      = ST_EN3,
    EX1      = ST_EX1,
    EX2      = ST_EX2,
    EX3      = ST_EX3,
    ERR      = ST_ERR,
    WAIT_CLR = ST_WAIT_CLR
  } state_t;

  localparam logic [1:0] CMD_HOLD = 2'b00;
  localparam logic [1:0] CMD_INC  = 2'b10;
  localparam logic [1:0] CMD_DEC  = 2'b01;

  // States in which a stalled vehicle is timed out.
  function automatic logic is_tracking(state_t s);
    return !(s == IDLE || s == WAIT_CLR);
  endfunction

endpackage

// File: rtl/parking_gate_sequencer_if.sv
// Sensor inputs, counter feedback and command/status outputs of the gate sequencer.
interface parking_gate_sequencer_if #(parameter int COUNT_W = 4);
  logic               sensor_a;
  logic               sensor_b;
  logic [COUNT_W-1:0] count;
  logic [1:0]         inc_dec;
  logic               lot_full;
  logic               busy;
  logic               seq_err;
  logic               reject;

  modport master (output sensor_a, sensor_b, count,
                  input  inc_dec, lot_full, busy, seq_err, reject);
  modport slave  (input  sensor_a, sensor_b, count,
                  output inc_dec, lot_full, busy, seq_err, reject);
endinterface

// File: rtl/parking_gate_sequencer_sensor_debounce.sv
// Two-flop synchroniser followed by a stable-level debounce counter for one beam sensor.
module sensor_debounce #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic deb
);
  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic          meta, sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= 1'b0;
      sync <= 1'b0;
      deb  <= 1'b0;
      cnt  <= '0;
    end else begin
      meta <= raw;
      sync <= meta;
      if (sync == deb) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYCLES-1)) begin
        deb <= sync;
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

// File: rtl/parking_gate_sequencer.sv
// Decodes the blocking order of the outer (A) and inner (B) beams into enter/exit
// commands for the occupancy counter, with full/empty rejection and stall timeout.
module parking_gate_sequencer
  import parking_gate_sequencer_pkg::*;
#(
  parameter int DEB_CYCLES = 16,
  parameter int TIMEOUT    = 1000000,
  parameter int COUNT_W    = 4,
  parameter int MAX_COUNT  = 15
) (
  input  logic                    clk,
  input  logic                    reset,
  parking_gate_sequencer_if.slave bus
);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [1:0]    raw, ab;
  state_t        state_q, state_d;
  logic [TW-1:0] tmo_q;
  logic [1:0]    cmd_d;
  logic          rej_d, full_now, empty_now, tmo_hit;

  assign raw = {bus.sensor_a, bus.sensor_b};

  // ab[1] is the outer beam, ab[0] the inner beam.
  sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb [1:0] (
    .clk   (clk),
    .reset (reset),
    .raw   (raw),
    .deb   (ab)
  );

  assign full_now  = (bus.count == COUNT_W'(MAX_COUNT));
  assign empty_now = (bus.count == '0);
  assign tmo_hit   = is_tracking(state_q) && (tmo_q == TW'(TIMEOUT-1));

  always_comb begin
    state_d = state_q;
    cmd_d   = CMD_HOLD;
    rej_d   = 1'b0;
    case (state_q)
      IDLE: case (ab)
        2'b10:   state_d = EN1;
        2'b01:   state_d = EX1;
        2'b00:   state_d = IDLE;
        default: state_d = ERR;
      endcase
      EN1: case (ab)
        2'b11:   state_d = EN2;
        2'b00:   state_d = IDLE;
        2'b10:   state_d = EN1;
        default: state_d = ERR;
      endcase
      EN2: case (ab)
        2'b01:   state_d = EN3;
        2'b10:   state_d = EN1;
        2'b11:   state_d = EN2;
        default: state_d = ERR;
      endcase
      EN3: case (ab)
        2'b00: begin
          state_d = IDLE;
          if (full_now) rej_d = 1'b1;
          else          cmd_d = CMD_INC;
        end
        2'b11:   state_d = EN2;
        2'b01:   state_d = EN3;
        default: state_d = ERR;
      endcase
      EX1: case (ab)
        2'b11:   state_d = EX2;
        2'b00:   state_d = IDLE;
        2'b01:   state_d = EX1;
        default: state_d = ERR;
      endcase
      EX2: case (ab)
        2'b10:   state_d = EX3;
        2'b01:   state_d = EX1;
        2'b11:   state_d = EX2;
        default: state_d = ERR;
      endcase
      EX3: case (ab)
        2'b00: begin
          state_d = IDLE;
          if (empty_now) rej_d = 1'b1;
          else           cmd_d = CMD_DEC;
        end
        2'b11:   state_d = EX2;
        2'b10:   state_d = EX3;
        default: state_d = ERR;
      endcase
      ERR:      state_d = WAIT_CLR;
      WAIT_CLR: if (ab == 2'b00) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    // A stall overrides whatever the sensors say this cycle.
    if (tmo_hit) begin
      state_d = ERR;
      cmd_d   = CMD_HOLD;
      rej_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q || !is_tracking(state_q)) tmo_q <= '0;
      else                                           tmo_q <= tmo_q + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.inc_dec  <= CMD_HOLD;
      bus.reject   <= 1'b0;
      bus.seq_err  <= 1'b0;
      bus.busy     <= 1'b0;
      bus.lot_full <= 1'b0;
    end else begin
      bus.inc_dec  <= cmd_d;
      bus.reject   <= rej_d;
      bus.seq_err  <= (state_d == ERR);
      bus.busy     <= (state_d != IDLE);
      bus.lot_full <= full_now;
    end
  end
endmodule

// File: tb/tb_parking_gate_sequencer.sv
// Directed bench for parking_gate_sequencer with a small model occupancy counter.
module tb_parking_gate_sequencer;
  logic       clk;
  logic       reset;
  logic       ld_en;
  logic [3:0] ld_val;
  int checks, failures;
  int n_inc, n_dec, n_rej, n_err, n_busy, n_bad, first_cmd;

  parking_gate_sequencer_if #(.COUNT_W(4)) bus ();

  parking_gate_sequencer #(
    .DEB_CYCLES(4), .TIMEOUT(100), .COUNT_W(4), .MAX_COUNT(15)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model occupancy counter driven by the DUT's command.
  always @(posedge clk) begin
    if (ld_en)                     bus.count <= ld_val;
    else if (bus.inc_dec == 2'b10) bus.count <= bus.count + 4'd1;
    else if (bus.inc_dec == 2'b01) bus.count <= bus.count - 4'd1;
  end

  task automatic clr_counts();
    n_inc = 0; n_dec = 0; n_rej = 0; n_err = 0; n_busy = 0; n_bad = 0; first_cmd = 0;
  endtask

  task automatic load_count(input logic [3:0] v);
    ld_val = v; ld_en = 1'b1;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  // Hold raw {a,b} for n cycles, tallying output pulses sampled 1ns after each edge.
  task automatic hold(input logic [1:0] ab, input int n);
    bus.sensor_a = ab[1];
    bus.sensor_b = ab[0];
    first_cmd = 0;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk); #1;
      if (bus.inc_dec == 2'b10) n_inc++;
      if (bus.inc_dec == 2'b01) n_dec++;
      if (bus.inc_dec == 2'b11) n_bad++;
      if (bus.reject)  n_rej++;
      if (bus.seq_err) n_err++;
      if (bus.busy)    n_busy++;
      if (bus.inc_dec != 2'b00 && first_cmd == 0) first_cmd = i;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    load_count(4'd0);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.inc_dec, bus.lot_full, bus.busy, bus.seq_err, bus.reject} !== 6'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=000000",
               {bus.inc_dec, bus.lot_full, bus.busy, bus.seq_err, bus.reject});
    end
    reset = 1'b1;
    clr_counts();
    hold(2'b00, 10);
    checks++;
    if (n_busy + n_inc + n_dec + n_rej + n_err !== 0) begin
      failures++;
      $display("FAIL reset_idle_activity got=%0d exp=0", n_busy + n_inc + n_dec + n_rej + n_err);
    end
  endtask

  task automatic test_clean_entry();
    load_count(4'd3);
    clr_counts();
    hold(2'b00, 10);
    checks++;
    if (bus.lot_full !== 1'b0) begin
      failures++; $display("FAIL entry_lot_full got=%b exp=0", bus.lot_full);
    end
    hold(2'b10, 10);
    hold(2'b11, 10);
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++; $display("FAIL entry_busy got=%b exp=1", bus.busy);
    end
    hold(2'b01, 10);
    hold(2'b00, 10);
    checks++;
    if (n_inc !== 1) begin
      failures++; $display("FAIL entry_inc_pulses got=%0d exp=1", n_inc);
    end
    checks++;
    if (first_cmd !== 7) begin
      failures++; $display("FAIL entry_latency got=%0d exp=7", first_cmd);
    end
    checks++;
    if (n_err !== 0 || n_dec !== 0 || n_rej !== 0) begin
      failures++; $display("FAIL entry_side_pulses got=%0d/%0d/%0d exp=0/0/0", n_err, n_dec, n_rej);
    end
    checks++;
    if (bus.count !== 4'd4) begin
      failures++; $display("FAIL entry_count got=%0d exp=4", bus.count);
    end
  endtask

  task automatic exit_seq();
    hold(2'b01, 10);
    hold(2'b11, 10);
    hold(2'b10, 10);
    hold(2'b00, 10);
  endtask

  task automatic test_exit();
    clr_counts();
    exit_seq();
    checks++;
    if (n_dec !== 1 || n_rej !== 0) begin
      failures++; $display("FAIL exit_dec got=%0d rej=%0d exp=1 rej=0", n_dec, n_rej);
    end
    checks++;
    if (bus.count !== 4'd3) begin
      failures++; $display("FAIL exit_count got=%0d exp=3", bus.count);
    end
    load_count(4'd0);
    clr_counts();
    exit_seq();
    checks++;
    if (n_rej !== 1 || n_dec !== 0) begin
      failures++; $display("FAIL exit_empty got rej=%0d dec=%0d exp rej=1 dec=0", n_rej, n_dec);
    end
    checks++;
    if (bus.count !== 4'd0) begin
      failures++; $display("FAIL exit_empty_count got=%0d exp=0", bus.count);
    end
  endtask

  task automatic test_full_lot();
    load_count(4'd15);
    clr_counts();
    hold(2'b00, 3);
    checks++;
    if (bus.lot_full !== 1'b1) begin
      failures++; $display("FAIL full_flag got=%b exp=1", bus.lot_full);
    end
    hold(2'b10, 10);
    hold(2'b11, 10);
    hold(2'b01, 10);
    hold(2'b00, 10);
    checks++;
    if (n_rej !== 1 || n_inc !== 0) begin
      failures++; $display("FAIL full_reject got rej=%0d inc=%0d exp rej=1 inc=0", n_rej, n_inc);
    end
    checks++;
    if (bus.count !== 4'd15) begin
      failures++; $display("FAIL full_count got=%0d exp=15", bus.count);
    end
  endtask

  task automatic test_backout_glitch();
    load_count(4'd5);
    clr_counts();
    hold(2'b10, 10);
    hold(2'b11, 10);
    hold(2'b10, 10);
    hold(2'b00, 10);
    checks++;
    if (n_inc + n_dec + n_rej + n_err !== 0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL backout got pulses=%0d busy=%b exp pulses=0 busy=0",
               n_inc + n_dec + n_rej + n_err, bus.busy);
    end
    clr_counts();
    for (int k = 0; k < 4; k++) begin
      hold(2'b10, 2);
      hold(2'b00, 6);
    end
    checks++;
    if (n_busy !== 0) begin
      failures++; $display("FAIL glitch_busy got=%0d exp=0", n_busy);
    end
  endtask

  task automatic test_errors();
    clr_counts();
    hold(2'b11, 10);
    checks++;
    if (n_err !== 1 || bus.busy !== 1'b1) begin
      failures++; $display("FAIL idle11_err got err=%0d busy=%b exp err=1 busy=1", n_err, bus.busy);
    end
    hold(2'b00, 10);
    checks++;
    if (bus.busy !== 1'b0 || n_inc + n_dec + n_rej !== 0) begin
      failures++; $display("FAIL waitclr_release got busy=%b cmds=%0d exp busy=0 cmds=0",
                           bus.busy, n_inc + n_dec + n_rej);
    end
    clr_counts();
    hold(2'b10, 10);
    hold(2'b01, 10);
    checks++;
    if (n_err !== 1) begin
      failures++; $display("FAIL jump_en1_err got=%0d exp=1", n_err);
    end
    hold(2'b00, 10);
    clr_counts();
    hold(2'b10, 150);
    checks++;
    if (n_err !== 1 || bus.busy !== 1'b1) begin
      failures++; $display("FAIL timeout_err got err=%0d busy=%b exp err=1 busy=1", n_err, bus.busy);
    end
    hold(2'b00, 10);
    checks++;
    if (bus.busy !== 1'b0 || n_inc !== 0) begin
      failures++; $display("FAIL timeout_clear got busy=%b inc=%0d exp busy=0 inc=0", bus.busy, n_inc);
    end
  endtask

  task automatic test_reset_mid_seq();
    load_count(4'd2);
    clr_counts();
    hold(2'b10, 10);
    hold(2'b11, 10);
    hold(2'b01, 10);
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++; $display("FAIL en3_busy got=%b exp=1", bus.busy);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({bus.inc_dec, bus.lot_full, bus.busy, bus.seq_err, bus.reject} !== 6'b0) begin
      failures++;
      $display("FAIL midseq_reset got=%b exp=000000",
               {bus.inc_dec, bus.lot_full, bus.busy, bus.seq_err, bus.reject});
    end
    hold(2'b00, 5);
    reset = 1'b1;
    clr_counts();
    hold(2'b00, 15);
    checks++;
    if (n_inc + n_busy + n_err !== 0 || bus.count !== 4'd2) begin
      failures++; $display("FAIL midseq_release got act=%0d count=%0d exp act=0 count=2",
                           n_inc + n_busy + n_err, bus.count);
    end
  endtask

  int bad_total;

  initial begin
    checks = 0; failures = 0; bad_total = 0;
    bus.sensor_a = 1'b0; bus.sensor_b = 1'b0;
    ld_en = 1'b0; ld_val = 4'd0; reset = 1'b0;
    clr_counts();
    test_reset();          bad_total += n_bad;
    test_clean_entry();    bad_total += n_bad;
    test_exit();           bad_total += n_bad;
    test_full_lot();       bad_total += n_bad;
    test_backout_glitch(); bad_total += n_bad;
    test_errors();         bad_total += n_bad;
    test_reset_mid_seq();  bad_total += n_bad;
    checks++;
    if (bad_total !== 0) begin
      failures++; $display("FAIL cmd_11_seen got=%0d exp=0", bad_total);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
